// File: rtl/otl_iq_defs.sv
// Shared I/Q sample layout and phase encoding for the TX unpacker and RX packer.
package otl_iq_defs;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned HALF_W   = 16;
  localparam int unsigned I_MSB    = 27;
  localparam int unsigned I_LSB    = 16;
  localparam int unsigned Q_MSB    = 11;
  localparam int unsigned Q_LSB    = 0;

  typedef enum logic {
    PH_I = 1'b0,
    PH_Q = 1'b1
  } phase_e;

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock show-ahead FIFO with explicit occupancy counter; pointers wrap modulo DEPTH.
module iq_sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  // Storage carries no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/dac_unpack.sv
// Buffers packed {I,Q} words and serializes them as I-then-Q 12-bit samples toward the DAC.
module dac_unpack
  import otl_iq_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                tx_clk,
  input  logic                tx_rst_n,
  input  logic [31:0]         dac_data,
  input  logic                dac_valid,
  output logic                dac_ready,
  input  logic                tx_en,
  input  logic                underflow_clr,
  output logic [SAMPLE_W-1:0] tx_data,
  output logic                tx_frame,
  output logic                underflow,
  output logic [AW:0]         fifo_level
);

  localparam int unsigned  FW   = 2 * SAMPLE_W;
  localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

  phase_e                phase_q, phase_d;
  logic [SAMPLE_W-1:0]   tx_data_q, tx_data_d;
  logic                  tx_frame_q, tx_frame_d;
  logic [SAMPLE_W-1:0]   q_hold_q, q_hold_d;
  logic                  underflow_q, underflow_d;
  logic                  ready_en_q;

  logic                  push, pop, starve;
  logic [FW-1:0]         wdata, head;
  logic [AW:0]           level;
  logic                  unused_bits;

  // Only the 12-bit samples are stored; the padding nibbles never reach the DAC.
  assign wdata       = {dac_data[I_MSB:I_LSB], dac_data[Q_MSB:Q_LSB]};
  assign unused_bits = ^{dac_data[31:28], dac_data[15:12]};

  assign dac_ready = ready_en_q && (level < FULL);
  assign push      = dac_valid && dac_ready;

  iq_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (tx_clk),
    .rst_n (tx_rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .level (level)
  );

  always_comb begin
    phase_d     = phase_q;
    tx_data_d   = '0;
    tx_frame_d  = 1'b0;
    q_hold_d    = q_hold_q;
    pop         = 1'b0;
    unique case (phase_q)
      PH_I: begin
        if (tx_en && (level != '0)) begin
          pop        = 1'b1;
          tx_data_d  = head[FW-1:SAMPLE_W];
          tx_frame_d = 1'b1;
          q_hold_d   = head[SAMPLE_W-1:0];
          phase_d    = PH_Q;
        end
      end
      PH_Q: begin
        // Q always follows its I so a pair is never split by tx_en.
        tx_data_d  = q_hold_q;
        tx_frame_d = 1'b1;
        phase_d    = PH_I;
      end
    endcase
  end

  assign starve = (phase_q == PH_I) && tx_en && (level == '0) && tx_frame_q;

  always_comb begin
    underflow_d = underflow_q;
    if (starve) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      phase_q     <= PH_I;
      tx_data_q   <= '0;
      tx_frame_q  <= 1'b0;
      q_hold_q    <= '0;
      underflow_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      tx_data_q   <= tx_data_d;
      tx_frame_q  <= tx_frame_d;
      q_hold_q    <= q_hold_d;
      underflow_q <= underflow_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_frame   = tx_frame_q;
  assign underflow  = underflow_q;
  assign fifo_level = level;

endmodule
